// File: rtl/psi_input_collector.sv
// psi_input_collector
// Collects N private sets of K unsigned W-bit elements, one element per
// accepted beat, checks each set is strictly ascending and exactly K long,
// and packs them into the flat vector consumed by the PSI core.
//
// Handshake rules, for both streams:
//   A beat transfers on a rising clock edge where valid and ready are both 1.
//   in_ready and out_valid depend only on registered state (and rst), never
//   on in_valid/out_ready, so there is no combinational path across the
//   stage. Inputs are ignored while their valid is low.
//
// Packing: party p element k sits at p_input[(p*K+k)*W +: W].

module psi_input_collector #(
  parameter int W = 32,
  parameter int K = 10,
  parameter int N = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [W-1:0]                      in_data,
  input  logic                              in_last,
  input  logic                              flush,
  output logic [W*K*N-1:0]                  p_input,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_error,
  output logic [1:0]                        err_code,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] party_idx,
  output logic [1:0]                        dbg_state
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(K - 1);
  localparam logic [PW-1:0] PIDX_LAST = PW'(N - 1);

  localparam logic [1:0] E_NONE  = 2'd0;
  localparam logic [1:0] E_ORDER = 2'd1;
  localparam logic [1:0] E_SHORT = 2'd2;
  localparam logic [1:0] E_LONG  = 2'd3;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FULL = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] elem_cnt, elem_cnt_n;
  logic [PW-1:0] party_n;
  logic [W-1:0]  prev, prev_n;
  logic [1:0]    err_n;
  logic          wr_en;
  logic          accept;

  // Stream-facing status decoded from the state register only.
  assign in_ready  = (state == S_LOAD) && !rst;
  assign out_valid = (state == S_FULL);
  assign out_error = (state == S_ERR);
  assign dbg_state = state;
  assign accept    = in_valid && in_ready;

  // Next-state logic: per-element order/length checks while loading,
  // output handshake while full; flush overrides everything.
  always_comb begin
    state_n    = state;
    elem_cnt_n = elem_cnt;
    party_n    = party_idx;
    prev_n     = prev;
    err_n      = err_code;
    wr_en      = 1'b0;

    case (state)
      S_LOAD: begin
        if (accept) begin
          if ((elem_cnt != '0) && (in_data <= prev)) begin
            // Duplicates count as order errors; the element is dropped.
            err_n   = E_ORDER;
            state_n = S_ERR;
          end else if (in_last && (elem_cnt < CNT_LAST)) begin
            err_n   = E_SHORT;
            state_n = S_ERR;
          end else if ((elem_cnt == CNT_LAST) && !in_last) begin
            err_n   = E_LONG;
            state_n = S_ERR;
          end else begin
            wr_en  = 1'b1;
            prev_n = in_data;
            if (elem_cnt == CNT_LAST) begin
              // Next party starts fresh: elem_cnt==0 skips the order check.
              elem_cnt_n = '0;
              if (party_idx == PIDX_LAST) begin
                party_n = '0;
                state_n = S_FULL;
              end else begin
                party_n = party_idx + 1'b1;
              end
            end else begin
              elem_cnt_n = elem_cnt + 1'b1;
            end
          end
        end
      end
      S_FULL: begin
        if (out_ready) begin
          state_n    = S_LOAD;
          elem_cnt_n = '0;
          party_n    = '0;
          prev_n     = '0;
        end
      end
      S_ERR: begin
        state_n = S_ERR;
      end
      default: begin
        state_n = S_LOAD;
      end
    endcase

    // Abort wins over a same-cycle accept or output handshake.
    if (flush) begin
      state_n    = S_LOAD;
      elem_cnt_n = '0;
      party_n    = '0;
      prev_n     = '0;
      err_n      = E_NONE;
      wr_en      = 1'b0;
    end
  end

  // Control registers: state, counters, last accepted element, error code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LOAD;
      elem_cnt  <= '0;
      party_idx <= '0;
      prev      <= '0;
      err_code  <= E_NONE;
    end else begin
      state     <= state_n;
      elem_cnt  <= elem_cnt_n;
      party_idx <= party_n;
      prev      <= prev_n;
      err_code  <= err_n;
    end
  end

  // Packed set storage: one slot written per good accept, otherwise held
  // (including across flush and the next load, which overwrites in place).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_input <= '0;
    end else begin
      for (int p = 0; p < N; p++) begin
        for (int k = 0; k < K; k++) begin
          if (wr_en && (party_idx == PW'(p)) && (elem_cnt == CW'(k))) begin
            p_input[(p*K+k)*W +: W] <= in_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_psi_input_collector.sv
// Bench for psi_input_collector with W=8, K=4, N=2. A queue-based model of
// the set-collection rules predicts every output each cycle; directed
// literal expectations pin the model at key points.

module tb_psi_input_collector;

  localparam int W = 8;
  localparam int K = 4;
  localparam int N = 2;
  localparam logic [63:0] T1_RESULT = 64'hC809030207050301;

  localparam int PH_LOAD = 0;
  localparam int PH_FULL = 1;
  localparam int PH_ERR  = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             flush;
  logic [W*K*N-1:0] p_input;
  logic             out_valid;
  logic             out_ready;
  logic             out_error;
  logic [1:0]       err_code;
  logic [0:0]       party_idx;
  logic [1:0]       dbg_state;

  int passed = 0;
  int total  = 0;

  psi_input_collector #(.W(W), .K(K), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .flush     (flush),
    .p_input   (p_input),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_error (out_error),
    .err_code  (err_code),
    .party_idx (party_idx),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_mem [N][K];
  logic [W-1:0] m_cur [$];
  int           m_phase;
  int           m_err;
  int           m_done;
  int           m_n;

  function automatic logic [63:0] model_packed();
    logic [63:0] v;
    v = '0;
    for (int p = 0; p < N; p++)
      for (int k = 0; k < K; k++)
        v[(p*K+k)*W +: W] = m_mem[p][k];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = PH_LOAD;
      m_err   = 0;
      m_done  = 0;
      m_cur.delete();
      for (int p = 0; p < N; p++)
        for (int k = 0; k < K; k++)
          m_mem[p][k] = '0;
    end else if (flush) begin
      m_phase = PH_LOAD;
      m_err   = 0;
      m_done  = 0;
      m_cur.delete();
    end else if (m_phase == PH_FULL) begin
      if (out_ready) begin
        m_phase = PH_LOAD;
        m_done  = 0;
      end
    end else if (m_phase == PH_LOAD && in_valid) begin
      m_n = m_cur.size();
      if (m_n > 0 && in_data <= m_cur[m_n-1]) begin
        m_err = 1; m_phase = PH_ERR;
      end else if (in_last && m_n + 1 < K) begin
        m_err = 2; m_phase = PH_ERR;
      end else if (m_n + 1 == K && !in_last) begin
        m_err = 3; m_phase = PH_ERR;
      end else begin
        m_mem[m_done][m_n] = in_data;
        m_cur.push_back(in_data);
        if (m_cur.size() == K) begin
          m_cur.delete();
          m_done++;
          if (m_done == N) begin
            m_done  = 0;
            m_phase = PH_FULL;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready",  64'(in_ready),  64'(m_phase == PH_LOAD));
      check("out_valid", 64'(out_valid), 64'(m_phase == PH_FULL));
      check("out_error", 64'(out_error), 64'(m_phase == PH_ERR));
      check("err_code",  64'(err_code),  64'(m_err));
      check("party_idx", 64'(party_idx), 64'(m_done));
      check("p_input",   p_input,        model_packed());
    end
  end

  // ---------------- drivers ----------------
  // All drivers are entered and left on a falling edge.
  task automatic push(input logic [W-1:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [W-1:0] t1_data [8] = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd2, 8'd3, 8'd9, 8'd200};

  task automatic load_t1(input int max_gap);
    for (int i = 0; i < 8; i++) begin
      push(t1_data[i], (i % K) == K - 1);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    idle(2);
    #2 rst = 1'b0;
    #1;
    check("reset p_input",   p_input,          64'h0);
    check("reset in_ready",  64'(in_ready),    64'h1);
    check("reset party_idx", 64'(party_idx),   64'h0);
    check("reset err_code",  64'(err_code),    64'h0);
    @(negedge clk);

    // 1: back-to-back load, result and one-cycle handshake
    load_t1(0);
    check("t1 out_valid", 64'(out_valid), 64'h1);
    check("t1 p_input",   p_input,        T1_RESULT);
    check("t1 in_ready",  64'(in_ready),  64'h0);
    check("t1 out_error", 64'(out_error), 64'h0);
    handshake();
    check("t1 back to load", 64'(in_ready),  64'h1);
    check("t1 party_idx",    64'(party_idx), 64'h0);

    // 2: duplicate element is an order error, flush clears it
    push(8'd4, 1'b0);
    push(8'd4, 1'b0);
    check("t2 out_error", 64'(out_error), 64'h1);
    check("t2 err_code",  64'(err_code),  64'h1);
    check("t2 in_ready",  64'(in_ready),  64'h0);
    push(8'd9, 1'b0);
    pulse_flush();
    check("t2 flush err_code", 64'(err_code), 64'h0);
    check("t2 flush in_ready", 64'(in_ready), 64'h1);

    // 3: short set, then long set
    push(8'd1, 1'b0);
    push(8'd2, 1'b1);
    check("t3 short err_code", 64'(err_code), 64'h2);
    pulse_flush();
    push(8'd1, 1'b0); push(8'd2, 1'b0); push(8'd3, 1'b0); push(8'd4, 1'b0);
    check("t3 long err_code", 64'(err_code), 64'h3);
    pulse_flush();

    // 4: gapped load, then 20 cycles of backpressure with in_valid pulses
    load_t1(3);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0]; in_data = W'($urandom_range(0, 255)); in_last = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("t4 held out_valid", 64'(out_valid), 64'h1);
    check("t4 held p_input",   p_input,        T1_RESULT);
    handshake();

    // 5: async reset between edges after five accepts, then reload
    for (int i = 0; i < 5; i++) push(t1_data[i], (i % K) == K - 1);
    #2 rst = 1'b1;
    #1;
    check("t5 rst p_input",   p_input,          64'h0);
    check("t5 rst out_valid", 64'(out_valid),   64'h0);
    check("t5 rst party_idx", 64'(party_idx),   64'h0);
    check("t5 rst out_error", 64'(out_error),   64'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    load_t1(0);
    check("t5 reload p_input", p_input, T1_RESULT);
    handshake();

    // 6: flush on the same cycle as the final accept
    for (int i = 0; i < 7; i++) push(t1_data[i], (i % K) == K - 1);
    flush = 1'b1;
    push(t1_data[7], 1'b1);
    flush = 1'b0;
    check("t6 out_valid", 64'(out_valid), 64'h0);
    check("t6 party_idx", 64'(party_idx), 64'h0);
    check("t6 in_ready",  64'(in_ready),  64'h1);
    idle(3);
    check("t6 still no out_valid", 64'(out_valid), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
